// File: rtl/data_mem_unit_pkg.sv
// Shared definitions for the data-side memory stage: default address map,
// MMIO register offsets and the address decode helper.
package data_mem_unit_pkg;

  localparam logic [31:0] DEF_DATA_BASE  = 32'h1001_0000;
  localparam logic [31:0] DEF_MMIO_BASE  = 32'hFFFF_0000;
  localparam int          DEF_DMEM_WORDS = 1024;

  // Byte offsets inside the 16-byte MMIO window
  localparam logic [3:0] MMIO_GPIO  = 4'h0;
  localparam logic [3:0] MMIO_CYCLE = 4'h4;
  localparam logic [3:0] MMIO_STORE = 4'h8;
  localparam logic [3:0] MMIO_FAULT = 4'hC;

  typedef enum logic [1:0] {
    HIT_RAM,
    HIT_MMIO,
    HIT_NONE
  } hit_e;

  // Classify a byte address; the MMIO window is matched on its 16-byte page.
  function automatic hit_e decode_addr(input logic [31:0] addr,
                                       input logic [31:0] data_base,
                                       input logic [31:0] ram_span,
                                       input logic [27:0] mmio_page);
    logic [31:0] rel;
    rel = addr - data_base;
    if ((addr >= data_base) && (rel < ram_span)) return HIT_RAM;
    if (addr[31:4] == mmio_page) return HIT_MMIO;
    return HIT_NONE;
  endfunction

endpackage

// File: rtl/data_mem_unit_dmem_ram.sv
// Single-port synchronous word RAM with a registered read port.
// A simultaneous write and read of the same word returns the new data.
module dmem_ram #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];
  logic [31:0] rdata_d;
  logic [31:0] rdata_q;

  // Array write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read register only moves on a read so the output holds between loads.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = we ? wdata : mem[addr];
  end

  // Read data register.
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_unit.sv
// Data memory stage: word RAM plus MMIO (GPIO, cycle counter, store counter,
// fault status). Load data is valid the cycle after the MEM-cycle strobe.
module data_mem_unit
  import data_mem_unit_pkg::*;
#(
  parameter logic [31:0] DATA_BASE  = DEF_DATA_BASE,
  parameter int          DMEM_WORDS = DEF_DMEM_WORDS,
  parameter logic [31:0] MMIO_BASE  = DEF_MMIO_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  output logic [31:0] dReadData,
  output logic [31:0] gpio_out,
  output logic        access_fault,
  output logic [31:0] fault_addr
);

  localparam int          AW       = $clog2(DMEM_WORDS);
  localparam logic [31:0] RAM_SPAN = 32'(DMEM_WORDS * 4);

  hit_e          hit;
  logic          aligned;
  logic          fault_ev;
  logic          legal_rd;
  logic          legal_wr;
  logic          ram_we;
  logic          ram_re;
  logic          mmio_wr;
  logic [3:0]    mmio_off;
  logic [AW-1:0] ram_idx;
  logic [31:0]   ram_rdata;
  logic [31:0]   mmio_rdata;

  logic        rd_sel_ram_d, rd_sel_ram_q;
  logic [31:0] rd_val_d,     rd_val_q;
  logic [31:0] gpio_d,       gpio_q;
  logic [31:0] cycle_cnt_d,  cycle_cnt_q;
  logic [31:0] store_cnt_d,  store_cnt_q;
  logic        fault_d,      fault_q;
  logic [31:0] fault_addr_d, fault_addr_q;

  // Request decode. RAM strobes are gated by reset so an in-flight store is dropped.
  always_comb begin
    hit      = decode_addr(dAddress, DATA_BASE, RAM_SPAN, MMIO_BASE[31:4]);
    aligned  = (dAddress[1:0] == 2'b00);
    mmio_off = dAddress[3:0];
    fault_ev = (MemRead || MemWrite) &&
               ((MemRead && MemWrite) || !aligned || (hit == HIT_NONE));
    legal_rd = MemRead  && !fault_ev;
    legal_wr = MemWrite && !fault_ev;
    ram_we   = rst && legal_wr && (hit == HIT_RAM);
    ram_re   = rst && legal_rd && (hit == HIT_RAM);
    mmio_wr  = legal_wr && (hit == HIT_MMIO);
    ram_idx  = AW'((dAddress - DATA_BASE) >> 2);
  end

  dmem_ram #(
    .WORDS (DMEM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_idx),
    .wdata (dWriteData),
    .rdata (ram_rdata)
  );

  // MMIO read mux; counters return their value before this cycle's increment.
  always_comb begin
    case (mmio_off)
      MMIO_GPIO:  mmio_rdata = gpio_q;
      MMIO_CYCLE: mmio_rdata = cycle_cnt_q;
      MMIO_STORE: mmio_rdata = store_cnt_q;
      MMIO_FAULT: mmio_rdata = {31'b0, fault_q};
      default:    mmio_rdata = 32'h0;
    endcase
  end

  // Next-state for MMIO registers, counters, fault capture and read path.
  always_comb begin
    rd_sel_ram_d = rd_sel_ram_q;
    rd_val_d     = rd_val_q;
    gpio_d       = gpio_q;
    cycle_cnt_d  = cycle_cnt_q + 32'd1;
    store_cnt_d  = store_cnt_q;
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;

    if (ram_we) store_cnt_d = store_cnt_q + 32'd1;

    if (mmio_wr && (mmio_off == MMIO_GPIO)) gpio_d = dWriteData;

    if (fault_ev) begin
      fault_d = 1'b1;
      if (!fault_q) fault_addr_d = dAddress;
    end else if (mmio_wr && (mmio_off == MMIO_FAULT)) begin
      fault_d      = 1'b0;
      fault_addr_d = 32'h0;
    end

    if (MemRead) begin
      rd_sel_ram_d = ram_re;
      rd_val_d     = (legal_rd && (hit == HIT_MMIO)) ? mmio_rdata : 32'h0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_sel_ram_q <= 1'b0;
      rd_val_q     <= 32'h0;
      gpio_q       <= 32'h0;
      cycle_cnt_q  <= 32'h0;
      store_cnt_q  <= 32'h0;
      fault_q      <= 1'b0;
      fault_addr_q <= 32'h0;
    end else begin
      rd_sel_ram_q <= rd_sel_ram_d;
      rd_val_q     <= rd_val_d;
      gpio_q       <= gpio_d;
      cycle_cnt_q  <= cycle_cnt_d;
      store_cnt_q  <= store_cnt_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign dReadData    = rd_sel_ram_q ? ram_rdata : rd_val_q;
  assign gpio_out     = gpio_q;
  assign access_fault = fault_q;
  assign fault_addr   = fault_addr_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed plus random bench for data_mem_unit against a behavioural model.
module tb_data_mem_unit;

  localparam logic [31:0] DB = 32'h1001_0000;
  localparam logic [31:0] MB = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] dAddress = 32'h0;
  logic [31:0] dWriteData = 32'h0;
  logic [31:0] dReadData;
  logic [31:0] gpio_out;
  logic        access_fault;
  logic [31:0] fault_addr;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [31:0] m_ram [int];
  logic [31:0] m_rd = 32'h0;
  logic [31:0] m_gpio = 32'h0;
  logic [31:0] m_store = 32'h0;
  logic        m_fault = 1'b0;
  logic [31:0] m_faddr = 32'h0;
  logic [31:0] cyc_total;
  logic [31:0] cyc_base = 32'h0;
  logic [31:0] cyc_mark = 32'h0;

  int pool [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 1020, 1021, 1022, 1023};

  data_mem_unit dut (
    .clk          (clk),
    .rst          (rst),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .dAddress     (dAddress),
    .dWriteData   (dWriteData),
    .dReadData    (dReadData),
    .gpio_out     (gpio_out),
    .access_fault (access_fault),
    .fault_addr   (fault_addr)
  );

  always #5 clk = ~clk;

  // Edges seen since reset release
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc_total <= 32'h0;
    else      cyc_total <= cyc_total + 32'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rd = 32'h0; m_gpio = 32'h0; m_store = 32'h0;
    m_fault = 1'b0; m_faddr = 32'h0;
    cyc_base = 32'h0; cyc_mark = 32'h0;
  endtask

  // One bus cycle, called at a negedge; model updated, then outputs checked.
  task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    bit          is_ram, is_mmio, illegal;
    logic [31:0] off;
    int          idx;
    is_ram  = (a >= DB) && (a < DB + 32'd4096);
    is_mmio = (a >= MB) && (a <= MB + 32'd15);
    illegal = (r || w) && ((r && w) || (a % 4 != 0) || !(is_ram || is_mmio));
    off     = a - MB;
    idx     = int'((a - DB) / 4);
    if (illegal) begin
      if (r) m_rd = 32'h0;
      if (!m_fault) m_faddr = a;
      m_fault = 1'b1;
    end else if (r) begin
      if (is_ram) m_rd = m_ram.exists(idx) ? m_ram[idx] : 32'hx;
      else if (off == 0)  m_rd = m_gpio;
      else if (off == 4)  m_rd = cyc_base + (cyc_total - cyc_mark);
      else if (off == 8)  m_rd = m_store;
      else                m_rd = {31'b0, m_fault};
    end else if (w) begin
      if (is_ram) begin
        m_ram[idx] = d;
        m_store = m_store + 32'd1;
      end else if (off == 0) m_gpio = d;
      else if (off == 12) begin
        m_fault = 1'b0;
        m_faddr = 32'h0;
      end
    end
    MemRead = r; MemWrite = w; dAddress = a; dWriteData = d;
    @(posedge clk);
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0;
    check("rdata", dReadData, m_rd);
    check("gpio", gpio_out, m_gpio);
    check("fault", {31'b0, access_fault}, {31'b0, m_fault});
    check("faddr", fault_addr, m_faddr);
  endtask

  initial begin
    int sel, op;
    logic [31:0] a, d;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rdata", dReadData, 32'h0);
    check("rst_gpio", gpio_out, 32'h0);
    check("rst_fault", {31'b0, access_fault}, 32'h0);
    check("rst_faddr", fault_addr, 32'h0);
    rst = 1'b1;
    model_reset();

    // 1: reset during a store
    step(1'b0, 1'b1, DB, 32'h1111_1111);
    step(1'b0, 1'b1, MB, 32'h0000_0077);
    step(1'b1, 1'b0, DB, 32'h0);
    MemWrite = 1'b1; dAddress = DB; dWriteData = 32'h2222_2222;
    #2 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    MemWrite = 1'b0;
    check("t1_rdata", dReadData, 32'h0);
    check("t1_gpio", gpio_out, 32'h0);
    check("t1_fault", {31'b0, access_fault}, 32'h0);
    check("t1_faddr", fault_addr, 32'h0);
    rst = 1'b1;
    model_reset();
    step(1'b1, 1'b0, DB, 32'h0);
    check("t1_ram_kept", dReadData, 32'h1111_1111);

    // 2: store then load back-to-back, store counter
    step(1'b0, 1'b1, DB + 32'd4, 32'hDEAD_BEEF);
    step(1'b1, 1'b0, DB + 32'd4, 32'h0);
    check("t2_load", dReadData, 32'hDEAD_BEEF);
    step(1'b1, 1'b0, MB + 32'd8, 32'h0);
    check("t2_store_cnt", dReadData, 32'h1);

    // 3: fault capture, sticky address, clear
    step(1'b1, 1'b0, DB + 32'd2, 32'h0);
    check("t3_rdata", dReadData, 32'h0);
    check("t3_faddr", fault_addr, 32'h1001_0002);
    step(1'b1, 1'b0, 32'h2000_0000, 32'h0);
    check("t3_faddr_kept", fault_addr, 32'h1001_0002);
    step(1'b0, 1'b1, MB + 32'hC, 32'h0);
    check("t3_clear", {31'b0, access_fault}, 32'h0);
    step(1'b1, 1'b0, DB + 32'd4096, 32'h0);
    check("t3_refault", fault_addr, DB + 32'd4096);
    step(1'b0, 1'b1, MB + 32'hC, 32'h0);

    // 4: GPIO write, read-only counter write ignored
    step(1'b0, 1'b1, MB, 32'h0000_00A5);
    check("t4_gpio", gpio_out, 32'h0000_00A5);
    step(1'b0, 1'b1, MB + 32'd4, 32'h1234_5678);
    check("t4_no_fault", {31'b0, access_fault}, 32'h0);
    step(1'b1, 1'b0, MB + 32'd4, 32'h0);

    // 5: cycle counter wrap
    force dut.cycle_cnt_q = 32'hFFFF_FFFF;
    cyc_base = 32'hFFFF_FFFF;
    cyc_mark = cyc_total;
    #1 release dut.cycle_cnt_q;
    @(negedge clk);
    @(negedge clk);
    step(1'b1, 1'b0, MB + 32'd4, 32'h0);
    check("t5_wrap", dReadData, 32'h1);

    // 6: read and write strobes together
    step(1'b0, 1'b1, DB + 32'd8, 32'h5A5A_0000);
    step(1'b1, 1'b1, DB + 32'd8, 32'h1);
    check("t6_rdata", dReadData, 32'h0);
    check("t6_fault", {31'b0, access_fault}, 32'h1);
    step(1'b1, 1'b0, DB + 32'd8, 32'h0);
    check("t6_ram_kept", dReadData, 32'h5A5A_0000);
    step(1'b0, 1'b1, MB + 32'hC, 32'h0);

    // Random traffic; every pool word is written first so loads are defined
    foreach (pool[i]) step(1'b0, 1'b1, DB + 32'(pool[i] * 4), $urandom);
    for (int n = 0; n < 300; n++) begin
      sel = int'($urandom_range(0, 9));
      d   = $urandom;
      if (sel <= 4)      a = DB + 32'(pool[$urandom_range(0, 11)] * 4);
      else if (sel <= 6) a = MB + 32'($urandom_range(0, 3) * 4);
      else if (sel == 7) a = DB + 32'(pool[$urandom_range(0, 11)] * 4) + 32'($urandom_range(1, 3));
      else if (sel == 8) a = ($urandom_range(0, 1) == 0) ? DB - 32'd4 : DB + 32'd4096;
      else               a = 32'h2000_0000 + ($urandom & 32'h00FF_FFFC);
      op = int'($urandom_range(0, 9));
      if (op <= 3)      step(1'b1, 1'b0, a, d);
      else if (op <= 7) step(1'b0, 1'b1, a, d);
      else if (op == 8) step(1'b1, 1'b1, a, d);
      else              step(1'b0, 1'b0, a, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
